burst_scheduler: RTL and testbench

Sequences the interrupter enable window for the DRSSTC. It produces a periodic `gate` pulse, whose on-time and period are set in microsecond-scale ticks, and clamps on-time to a hard maximum. It counts over-current (OCD) events per burst and latches a fault lockout after too many consecutive faulted bursts. It sits upstream of the interrupter and feeds the signal that the interrupter combines with resonant feedback.

---
 rtl/drsstc_pkg.sv | 14 +
 rtl/sync.sv | 24 ++
 rtl/tick_gen.sv | 34 +++
 rtl/burst_scheduler.sv | 168 ++++++++++++++++
 tb/tb_burst_scheduler.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/drsstc_pkg.sv
// Shared types and default constants for the DRSSTC control blocks.
package drsstc_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StOn   = 2'd1,
        StOff  = 2'd2,
        StLock = 2'd3
    } burst_state_t;

    localparam int unsigned TICK_DIV_DEF = 100;
    localparam int unsigned MAX_ON_DEF   = 200;

endpackage

// File: rtl/sync.sv
// Two-flop synchronizer for a single asynchronous level.
module sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/tick_gen.sv
// Prescaler: one-cycle tick strobe every DIV clocks, restartable by clr_i.
module tick_gen #(
    parameter int unsigned DIV = 100
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CntW-1:0] Last = CntW'(DIV - 1);

    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + CntW'(1);
        if (clr_i || (cnt_q == Last)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == Last);

endmodule

// File: rtl/burst_scheduler.sv
// Interrupter enable-window sequencer: periodic clamped gate pulse with OCD fault lockout.
module burst_scheduler
    import drsstc_pkg::*;
#(
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned TICK_DIV  = TICK_DIV_DEF,
    parameter int unsigned MAX_ON    = MAX_ON_DEF,
    parameter int unsigned FAULT_MAX = 4,
    localparam int unsigned FC_W     = $clog2(FAULT_MAX + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] period_i,
    input  logic [CNT_W-1:0] on_time_i,
    input  logic             ocd_i,
    output logic             gate_o,
    output logic             fault_lock_o,
    output logic [FC_W-1:0]  fault_cnt_o,
    output logic             busy_o
);

    localparam logic [CNT_W-1:0] MaxOnC  = CNT_W'(MAX_ON);
    localparam logic [FC_W-1:0]  FcMaxC  = FC_W'(FAULT_MAX);

    burst_state_t     state_q, state_d;
    logic [CNT_W-1:0] tcnt_q, tcnt_d;
    logic [CNT_W-1:0] per_q, per_d;
    logic [CNT_W-1:0] on_q, on_d;
    logic             faulted_q, faulted_d;
    logic [FC_W-1:0]  fcnt_q, fcnt_d;
    logic             gate_q;
    logic             lock_q;

    logic             ocd_s;
    logic             tick;
    logic             clr;
    logic             launch;
    logic             start;
    logic [CNT_W-1:0] tcnt_inc;
    logic [CNT_W-1:0] on_lim;
    logic [CNT_W-1:0] on_clamp;
    logic [FC_W-1:0]  fcnt_end;

    sync u_ocd_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (ocd_i),
        .q_o   (ocd_s)
    );

    tick_gen #(
        .DIV (TICK_DIV)
    ) u_tick_gen (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (clr),
        .tick_o (tick)
    );

    // Clamp: min(on_time, MAX_ON, period-1); period 0 never launches a burst.
    always_comb begin
        on_lim   = (on_time_i < MaxOnC) ? on_time_i : MaxOnC;
        on_clamp = (on_lim < (period_i - CNT_W'(1))) ? on_lim : (period_i - CNT_W'(1));
    end

    assign start    = en_i && (period_i != '0);
    assign tcnt_inc = tcnt_q + CNT_W'(1);

    always_comb begin
        state_d   = state_q;
        tcnt_d    = tcnt_q;
        per_d     = per_q;
        on_d      = on_q;
        faulted_d = faulted_q;
        fcnt_d    = fcnt_q;
        clr       = 1'b0;
        launch    = 1'b0;
        fcnt_end  = '0;
        if (faulted_q) begin
            fcnt_end = (fcnt_q == FcMaxC) ? fcnt_q : fcnt_q + FC_W'(1);
        end

        unique case (state_q)
            StIdle: begin
                launch = start;
            end
            StOn: begin
                if (tick) begin
                    tcnt_d = tcnt_inc;
                end
                if (!en_i) begin
                    state_d = StIdle;
                end else if (ocd_s) begin
                    state_d   = StOff;
                    faulted_d = 1'b1;
                    clr       = 1'b1;
                end else if (tick && (tcnt_inc == on_q)) begin
                    state_d = StOff;
                    clr     = 1'b1;
                end
            end
            StOff: begin
                if (tick) begin
                    tcnt_d = tcnt_inc;
                end
                if (!en_i) begin
                    state_d = StIdle;
                end else if (tick && (tcnt_inc == per_q)) begin
                    fcnt_d = fcnt_end;
                    if (fcnt_end == FcMaxC) begin
                        state_d = StLock;
                    end else if (start) begin
                        launch = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StLock: begin
                if (!en_i) begin
                    state_d = StIdle;
                    fcnt_d  = '0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (launch) begin
            per_d     = period_i;
            on_d      = on_clamp;
            tcnt_d    = '0;
            faulted_d = 1'b0;
            clr       = 1'b1;
            state_d   = (on_clamp == '0) ? StOff : StOn;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            tcnt_q    <= '0;
            per_q     <= '0;
            on_q      <= '0;
            faulted_q <= 1'b0;
            fcnt_q    <= '0;
            gate_q    <= 1'b0;
            lock_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tcnt_q    <= tcnt_d;
            per_q     <= per_d;
            on_q      <= on_d;
            faulted_q <= faulted_d;
            fcnt_q    <= fcnt_d;
            gate_q    <= (state_d == StOn);
            lock_q    <= (state_d == StLock);
        end
    end

    assign gate_o       = gate_q;
    assign fault_lock_o = lock_q;
    assign fault_cnt_o  = fcnt_q;
    assign busy_o       = (state_q != StIdle);

endmodule

// File: tb/tb_burst_scheduler.sv
// Directed bench for burst_scheduler with TICK_DIV=2, MAX_ON=5, FAULT_MAX=2.
module tb_burst_scheduler;

    localparam int unsigned CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic [CNT_W-1:0] period = '0;
    logic [CNT_W-1:0] on_time = '0;
    logic             ocd = 1'b0;
    logic             gate;
    logic             fault_lock;
    logic [1:0]       fault_cnt;
    logic             busy;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    typedef struct {
        int per;
        int on;
        int exp_hi;
        int exp_lo;
    } vec_t;

    vec_t vecs[5];

    burst_scheduler #(
        .CNT_W     (CNT_W),
        .TICK_DIV  (2),
        .MAX_ON    (5),
        .FAULT_MAX (2)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .en_i         (en),
        .period_i     (period),
        .on_time_i    (on_time),
        .ocd_i        (ocd),
        .gate_o       (gate),
        .fault_lock_o (fault_lock),
        .fault_cnt_o  (fault_cnt),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Counts negedges while gate holds the given level, bounded by lim.
    task automatic count_while(input logic lvl, input int lim, output int n);
        n = 0;
        while ((gate === lvl) && (n < lim)) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic wait_rise(input string name);
        int n;
        n = 0;
        while ((gate !== 1'b1) && (n < 100)) begin
            n++;
            @(negedge clk);
        end
        if (gate !== 1'b1) chk({name, "_rise_timeout"}, 0, 1);
    endtask

    // Called at the negedge where gate is first seen high.
    task automatic ocd_burst(input string name);
        int k;
        repeat (3) @(negedge clk);
        ocd = 1'b1;
        @(negedge clk);
        ocd = 1'b0;
        k = 1;
        while (gate && (k < 20)) begin
            @(negedge clk);
            k++;
        end
        chk({name, "_ocd_latency"}, k, 3);
    endtask

    initial begin
        int lat, hi, lo, n, c0;

        vecs[0] = '{per: 10, on: 3, exp_hi: 6,  exp_lo: 14};
        vecs[1] = '{per: 10, on: 8, exp_hi: 10, exp_lo: 10};
        vecs[2] = '{per: 4,  on: 4, exp_hi: 6,  exp_lo: 2};
        vecs[3] = '{per: 6,  on: 5, exp_hi: 10, exp_lo: 2};
        vecs[4] = '{per: 3,  on: 1, exp_hi: 2,  exp_lo: 4};

        #2;
        chk("rst_gate", int'(gate), 0);
        chk("rst_lock", int'(fault_lock), 0);
        chk("rst_cnt", int'(fault_cnt), 0);
        chk("rst_busy", int'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            en = 1'b0;
            period = CNT_W'(vecs[i].per);
            on_time = CNT_W'(vecs[i].on);
            repeat (2) @(negedge clk);
            chk($sformatf("v%0d_idle_busy", i), int'(busy), 0);
            en = 1'b1;
            lat = 0;
            do begin
                @(negedge clk);
                lat++;
            end while (!gate && lat < 50);
            chk($sformatf("v%0d_startup", i), lat, 1);
            count_while(1'b1, 200, hi);
            count_while(1'b0, 200, lo);
            chk($sformatf("v%0d_high", i), hi, vecs[i].exp_hi);
            chk($sformatf("v%0d_low", i), lo, vecs[i].exp_lo);
            chk($sformatf("v%0d_fcnt", i), int'(fault_cnt), 0);
        end

        // period=0 never starts; period=1 runs with gate held low.
        en = 1'b0;
        repeat (2) @(negedge clk);
        period = 16'd0;
        on_time = 16'd3;
        en = 1'b1;
        repeat (3) @(negedge clk);
        chk("per0_busy", int'(busy), 0);
        period = 16'd1;
        @(negedge clk);
        n = 0;
        for (int j = 0; j < 30; j++) begin
            if (gate) n++;
            @(negedge clk);
        end
        chk("per1_gate_highs", n, 0);
        chk("per1_busy", int'(busy), 1);
        en = 1'b0;
        repeat (2) @(negedge clk);

        // OCD cut-off, fault count held through a disable, then cleared by a clean burst.
        period = 16'd10;
        on_time = 16'd5;
        en = 1'b1;
        wait_rise("ocd1");
        ocd_burst("ocd1");
        wait_rise("ocd1_next");
        chk("ocd1_fcnt", int'(fault_cnt), 1);
        repeat (2) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        chk("dis_gate", int'(gate), 0);
        chk("dis_busy", int'(busy), 0);
        chk("dis_fcnt_held", int'(fault_cnt), 1);
        en = 1'b1;
        wait_rise("clean");
        count_while(1'b1, 100, hi);
        chk("clean_high", hi, 10);
        wait_rise("clean_next");
        chk("clean_fcnt", int'(fault_cnt), 0);

        // Two consecutive faulted bursts lock out at the end of the second.
        ocd_burst("lockA");
        wait_rise("lockA_next");
        chk("lockA_fcnt", int'(fault_cnt), 1);
        c0 = cyc;
        ocd_burst("lockB");
        n = 0;
        while (!fault_lock && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("lock_entry_cycle", cyc - c0, 20);
        chk("lock_fcnt", int'(fault_cnt), 2);
        chk("lock_busy", int'(busy), 1);
        n = 0;
        for (int j = 0; j < 40; j++) begin
            if (gate || !fault_lock) n++;
            @(negedge clk);
        end
        chk("lock_hold_violations", n, 0);
        en = 1'b0;
        @(negedge clk);
        chk("unlock_lock", int'(fault_lock), 0);
        chk("unlock_fcnt", int'(fault_cnt), 0);
        chk("unlock_busy", int'(busy), 0);

        // Asynchronous reset mid-ON.
        en = 1'b1;
        wait_rise("arst");
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("arst_gate", int'(gate), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_lock", int'(fault_lock), 0);
        chk("arst_fcnt", int'(fault_cnt), 0);
        en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_gate", int'(gate), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1);
    end

endmodule
